conv_engine_seq: RTL and testbench

//  Sequential, parametrised successor of the combinational convolution coprocessor.

---
 rtl/conv_engine_seq_if.sv | 31 +++
 rtl/conv_engine_seq.sv | 180 ++++++++++++++++++
 tb/tb_conv_engine_seq.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_engine_seq_if.sv
// Request/result bundle between the instruction decoder and the convolution engine.
interface conv_engine_seq_if #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int ACC_W   = 16
);
    localparam int MW = MAX_DIM * MAX_DIM * ELEM_W;

    logic                    start;
    logic [2:0]              op_code;
    logic [1:0]              matrix_size;
    logic [MW-1:0]           matrix_a;
    logic [MW-1:0]           matrix_b;
    logic [MW-1:0]           matrix_c;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic signed [ACC_W-1:0] result_gx;
    logic signed [ACC_W-1:0] result_gy;
    logic [ACC_W-1:0]        result_mag;
    logic [7:0]              result_pix;

    modport master (
        output start, op_code, matrix_size, matrix_a, matrix_b, matrix_c,
        input  busy, done, error, result_gx, result_gy, result_mag, result_pix
    );
    modport slave (
        input  start, op_code, matrix_size, matrix_a, matrix_b, matrix_c,
        output busy, done, error, result_gx, result_gy, result_mag, result_pix
    );
endinterface

// File: rtl/conv_engine_seq.sv
// Sequential convolution engine: Laplacian or gradient magnitude over an NxN window,
// one MAC per element followed by a restoring bit-serial integer square root.
module conv_engine_seq #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int ACC_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    conv_engine_seq_if.slave bus
);
    localparam int MW    = MAX_DIM * MAX_DIM * ELEM_W;
    localparam int AW    = 2 * ELEM_W + 5;
    localparam int EW2   = 2 * ELEM_W;
    localparam int PW    = 2 * ACC_W;
    localparam int RW    = ACC_W + 1;
    localparam int IDX_W = $clog2(MAX_DIM * MAX_DIM);
    localparam int CNT_W = $clog2(ACC_W);
    localparam logic signed [AW-1:0]    LIM_HI  = AW'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
    localparam logic signed [AW-1:0]    LIM_LO  = ~LIM_HI;
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(255);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_SQRT, S_DONE} state_t;
    state_t state, state_nxt;

    logic                    grad_q, err_q, bad_op, last_elem, load_res;
    logic [2:0]              n_q, row_q, col_q, n_in;
    logic [MW-1:0]           ma_q, mb_q, mc_q;
    logic [IDX_W-1:0]        idx;
    logic signed [EW2-1:0]   ea, eb, ec, px, py;
    logic signed [AW-1:0]    acc_x, acc_y, sum_x, sum_y;
    logic signed [ACC_W-1:0] gx_q, gy_q, sat_x, sat_y;
    logic signed [PW-1:0]    wx, wy;
    logic [PW-1:0]           op_sh, sq_sum;
    logic [RW-1:0]           rem_q;
    logic [RW+1:0]           rem_t, trial;
    logic [ACC_W-1:0]        root_q, root_nxt;
    logic [CNT_W-1:0]        sq_cnt;
    logic signed [ACC_W-1:0] res_gx_q, res_gy_q, res_gx_nxt, res_gy_nxt;
    logic [ACC_W-1:0]        res_mag_q, res_mag_nxt;
    logic [7:0]              res_pix_q, res_pix_nxt;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [AW-1:0] v);
        if (v > LIM_HI) return LIM_HI[ACC_W-1:0];
        if (v < LIM_LO) return LIM_LO[ACC_W-1:0];
        return v[ACC_W-1:0];
    endfunction

    assign n_in   = {1'b0, bus.matrix_size} + 3'd2;
    assign bad_op = !(bus.op_code inside {3'b110, 3'b111}) || (int'(n_in) > MAX_DIM);

    // Row-major walk over the active NxN corner of the MAX_DIM-wide flat matrices
    assign idx       = IDX_W'(int'(row_q) * MAX_DIM + int'(col_q));
    assign last_elem = (row_q == n_q - 3'd1) && (col_q == n_q - 3'd1);
    assign ea        = EW2'($signed(ma_q[idx*ELEM_W +: ELEM_W]));
    assign eb        = EW2'($signed(mb_q[idx*ELEM_W +: ELEM_W]));
    assign ec        = EW2'($signed(mc_q[idx*ELEM_W +: ELEM_W]));
    assign px        = ea * eb;
    assign py        = ea * ec;
    assign sum_x     = acc_x + AW'(px);
    assign sum_y     = acc_y + AW'(py);
    assign sat_x     = sat(sum_x);
    assign sat_y     = sat(sum_y);
    assign wx        = PW'(sat_x);
    assign wy        = PW'(sat_y);
    assign sq_sum    = wx * wx + wy * wy;

    // One root bit per cycle: try subtracting (4*root+1) from the shifted remainder
    assign rem_t    = {rem_q, op_sh[PW-1 -: 2]};
    assign trial    = {1'b0, root_q, 2'b01};
    assign root_nxt = {root_q[ACC_W-2:0], rem_t >= trial};

    always_comb begin
        state_nxt   = state;
        res_gx_nxt  = '0;
        res_gy_nxt  = '0;
        res_mag_nxt = '0;
        res_pix_nxt = '0;
        case (state)
            S_IDLE: if (bus.start) state_nxt = bad_op ? S_DONE : S_MAC;
            S_MAC: begin
                res_gx_nxt = sat_x;
                if (sat_x < 0)            res_pix_nxt = 8'h00;
                else if (sat_x > PIX_MAX) res_pix_nxt = 8'hFF;
                else                      res_pix_nxt = sat_x[7:0];
                if (last_elem) state_nxt = grad_q ? S_SQRT : S_DONE;
            end
            S_SQRT: begin
                res_gx_nxt  = gx_q;
                res_gy_nxt  = gy_q;
                res_mag_nxt = root_nxt;
                res_pix_nxt = (root_nxt > ACC_W'(255)) ? 8'hFF : root_nxt[7:0];
                if (sq_cnt == CNT_W'(ACC_W - 1)) state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign load_res = (state != S_DONE) && (state_nxt == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            grad_q    <= 1'b0;
            err_q     <= 1'b0;
            n_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            mc_q      <= '0;
            acc_x     <= '0;
            acc_y     <= '0;
            gx_q      <= '0;
            gy_q      <= '0;
            op_sh     <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            sq_cnt    <= '0;
            res_gx_q  <= '0;
            res_gy_q  <= '0;
            res_mag_q <= '0;
            res_pix_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (bus.start) begin
                    grad_q <= (bus.op_code == 3'b111);
                    err_q  <= bad_op;
                    n_q    <= n_in;
                    ma_q   <= bus.matrix_a;
                    mb_q   <= bus.matrix_b;
                    mc_q   <= bus.matrix_c;
                    row_q  <= '0;
                    col_q  <= '0;
                    acc_x  <= '0;
                    acc_y  <= '0;
                end
                S_MAC: begin
                    acc_x  <= sum_x;
                    acc_y  <= sum_y;
                    gx_q   <= sat_x;
                    gy_q   <= sat_y;
                    op_sh  <= sq_sum;
                    rem_q  <= '0;
                    root_q <= '0;
                    sq_cnt <= '0;
                    if (col_q == n_q - 3'd1) begin
                        col_q <= '0;
                        row_q <= row_q + 3'd1;
                    end else begin
                        col_q <= col_q + 3'd1;
                    end
                end
                S_SQRT: begin
                    op_sh  <= op_sh << 2;
                    rem_q  <= (rem_t >= trial) ? RW'(rem_t - trial) : RW'(rem_t);
                    root_q <= root_nxt;
                    sq_cnt <= sq_cnt + CNT_W'(1);
                end
                default: ;
            endcase
            if (load_res) begin
                res_gx_q  <= res_gx_nxt;
                res_gy_q  <= res_gy_nxt;
                res_mag_q <= res_mag_nxt;
                res_pix_q <= res_pix_nxt;
            end
        end
    end

    assign bus.busy       = (state == S_MAC) || (state == S_SQRT);
    assign bus.done       = (state == S_DONE);
    assign bus.error      = err_q;
    assign bus.result_gx  = res_gx_q;
    assign bus.result_gy  = res_gy_q;
    assign bus.result_mag = res_mag_q;
    assign bus.result_pix = res_pix_q;
endmodule

// File: tb/tb_conv_engine_seq.sv
// Randomized bench for conv_engine_seq: an arithmetic reference model tracks the
// expected handshake and results every cycle, plus hand-computed directed cases.
module tb_conv_engine_seq;
    localparam int ELEM_W  = 8;
    localparam int MAX_DIM = 5;
    localparam int ACC_W   = 16;
    localparam int NE      = MAX_DIM * MAX_DIM;
    localparam int MW      = NE * ELEM_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv_engine_seq_if #(.ELEM_W(ELEM_W), .MAX_DIM(MAX_DIM), .ACC_W(ACC_W)) bus ();
    conv_engine_seq #(.ELEM_W(ELEM_W), .MAX_DIM(MAX_DIM), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    int lapk [9] = '{0, 1, 0, 1, -4, 1, 0, 1, 0};
    int sobx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int soby [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int el(input logic [MW-1:0] m, input int r, input int c);
        logic signed [ELEM_W-1:0] v;
        v = m[(r * MAX_DIM + c) * ELEM_W +: ELEM_W];
        return int'(v);
    endfunction

    function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int r, input int c, input int v);
        m[(r * MAX_DIM + c) * ELEM_W +: ELEM_W] = ELEM_W'(v);
        return m;
    endfunction

    function automatic logic [MW-1:0] fill(input int v);
        logic [MW-1:0] m;
        for (int i = 0; i < NE; i++) m[i * ELEM_W +: ELEM_W] = ELEM_W'(v);
        return m;
    endfunction

    function automatic logic [MW-1:0] rand_mat(input int mode);
        logic [MW-1:0] m;
        int v;
        for (int i = 0; i < NE; i++) begin
            case (mode)
                0:       v = int'($urandom_range(0, 255)) - 128;
                1:       v = ($urandom_range(0, 1) == 1) ? 127 : -128;
                default: v = int'($urandom_range(0, 20)) - 10;
            endcase
            m[i * ELEM_W +: ELEM_W] = ELEM_W'(v);
        end
        return m;
    endfunction

    function automatic longint satl(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint isqrt(input longint s);
        longint lo, hi, mid;
        lo = 0;
        hi = 65536;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= s) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    // Reference model: cycles since accept (-1 when idle) and the visible results
    int     m_phase = -1;
    int     m_lat   = 1;
    longint m_gx = 0, m_gy = 0, m_mag = 0, m_pix = 0, m_err = 0;
    longint p_gx, p_gy, p_mag, p_pix, p_err;

    task automatic model_accept(input logic [2:0] op, input logic [1:0] sz,
                                input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [MW-1:0] c);
        int n;
        longint sx, sy;
        n = int'(sz) + 2;
        p_gx = 0; p_gy = 0; p_mag = 0; p_pix = 0; p_err = 0;
        if (!(op == 3'b110 || op == 3'b111) || n > MAX_DIM) begin
            p_err = 1;
            m_lat = 1;
        end else begin
            sx = 0;
            sy = 0;
            for (int r = 0; r < n; r++)
                for (int cc = 0; cc < n; cc++) begin
                    sx += longint'(el(a, r, cc) * el(b, r, cc));
                    sy += longint'(el(a, r, cc) * el(c, r, cc));
                end
            p_gx = satl(sx);
            if (op == 3'b110) begin
                p_pix = (p_gx < 0) ? 0 : ((p_gx > 255) ? 255 : p_gx);
                m_lat = n * n + 1;
            end else begin
                p_gy  = satl(sy);
                p_mag = isqrt(p_gx * p_gx + p_gy * p_gy);
                p_pix = (p_mag > 255) ? 255 : p_mag;
                m_lat = n * n + ACC_W + 1;
            end
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_phase = -1;
            m_gx = 0; m_gy = 0; m_mag = 0; m_pix = 0; m_err = 0;
        end else begin
            if (m_phase < 0) begin
                if (bus.start === 1'b1) begin
                    model_accept(bus.op_code, bus.matrix_size, bus.matrix_a, bus.matrix_b, bus.matrix_c);
                    m_phase = 1;
                end
            end else if (m_phase == m_lat) m_phase = -1;
            else m_phase++;
            if (m_phase > 0 && m_phase == m_lat) begin
                m_gx = p_gx; m_gy = p_gy; m_mag = p_mag; m_pix = p_pix; m_err = p_err;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", longint'(bus.busy), longint'(m_phase >= 1 && m_phase < m_lat));
            chk("done", longint'(bus.done), longint'(m_phase == m_lat));
            chk("gx",   longint'(bus.result_gx),  m_gx);
            chk("gy",   longint'(bus.result_gy),  m_gy);
            chk("mag",  longint'(bus.result_mag), m_mag);
            chk("pix",  longint'(bus.result_pix), m_pix);
            if (m_phase < 0 || m_phase == m_lat) chk("error", longint'(bus.error), m_err);
        end
    end

    // Issue one request; returns the cycle number (accept = 0) on which done was seen
    task automatic run_op(input logic [2:0] op, input logic [1:0] sz,
                          input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [MW-1:0] c,
                          input int extra_start_at, output int cyc);
        @(negedge clk);
        bus.op_code = op; bus.matrix_size = sz;
        bus.matrix_a = a; bus.matrix_b = b; bus.matrix_c = c;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_code = 3'($urandom_range(0, 7));
        bus.matrix_a = rand_mat(0); bus.matrix_b = rand_mat(0); bus.matrix_c = rand_mat(0);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 200) begin
            bus.start = (cyc == extra_start_at);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        if (bus.done !== 1'b1) chk("done_timeout", longint'(bus.done), 1);
    endtask

    initial begin
        logic [MW-1:0] a, b, c;
        int cyc, ndone;
        bus.start = 1'b0; bus.op_code = '0; bus.matrix_size = '0;
        bus.matrix_a = '0; bus.matrix_b = '0; bus.matrix_c = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_done", longint'(bus.done), 0);
        chk("rst_error", longint'(bus.error), 0);
        chk("rst_gx", longint'(bus.result_gx), 0);
        chk("rst_pix", longint'(bus.result_pix), 0);
        reset = 1'b0;

        // Laplacian on a flat 3x3 patch
        a = fill(7); b = fill(3); c = fill(9);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++) begin
                a = put(a, r, k, 1);
                b = put(b, r, k, lapk[r * 3 + k]);
            end
        run_op(3'b110, 2'd1, a, b, c, 0, cyc);
        chk("t1_cycle", cyc, 10);
        chk("t1_gx", longint'(bus.result_gx), 0);
        chk("t1_pix", longint'(bus.result_pix), 0);
        chk("t1_error", longint'(bus.error), 0);

        // Sobel gradient on a vertical ramp
        a = fill(50); b = fill(1); c = fill(1);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++) begin
                a = put(a, r, k, 10 * (r + 1));
                b = put(b, r, k, sobx[r * 3 + k]);
                c = put(c, r, k, soby[r * 3 + k]);
            end
        run_op(3'b111, 2'd1, a, b, c, 0, cyc);
        chk("t2_cycle", cyc, 26);
        chk("t2_gx", longint'(bus.result_gx), 0);
        chk("t2_gy", longint'(bus.result_gy), 80);
        chk("t2_mag", longint'(bus.result_mag), 80);
        chk("t2_pix", longint'(bus.result_pix), 80);

        // Saturation, both modes
        a = fill(127);
        run_op(3'b111, 2'd3, a, a, a, 0, cyc);
        chk("t3_cycle", cyc, 42);
        chk("t3_gx", longint'(bus.result_gx), 32767);
        chk("t3_gy", longint'(bus.result_gy), 32767);
        chk("t3_mag", longint'(bus.result_mag), 46339);
        chk("t3_pix", longint'(bus.result_pix), 255);
        run_op(3'b110, 2'd3, a, a, a, 0, cyc);
        chk("t3l_gx", longint'(bus.result_gx), 32767);
        chk("t3l_pix", longint'(bus.result_pix), 255);
        chk("t3l_mag", longint'(bus.result_mag), 0);

        // Invalid op code
        run_op(3'b000, 2'd2, a, a, a, 0, cyc);
        chk("t5_cycle", cyc, 1);
        chk("t5_error", longint'(bus.error), 1);
        chk("t5_gx", longint'(bus.result_gx), 0);
        chk("t5_mag", longint'(bus.result_mag), 0);

        // Negative Laplacian with a stray start during MAC
        run_op(3'b110, 2'd0, fill(1), fill(-1), fill(1), 2, cyc);
        chk("t4_cycle", cyc, 5);
        chk("t4_gx", longint'(bus.result_gx), -4);
        chk("t4_pix", longint'(bus.result_pix), 0);
        chk("t4_error", longint'(bus.error), 0);
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        chk("t4_extra_done", ndone, 0);

        // Reset in the middle of MAC
        @(negedge clk);
        bus.op_code = 3'b110; bus.matrix_size = 2'd1;
        bus.matrix_a = fill(5); bus.matrix_b = fill(5); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_busy", longint'(bus.busy), 0);
        chk("t6_done", longint'(bus.done), 0);
        chk("t6_gx", longint'(bus.result_gx), 0);
        chk("t6_pix", longint'(bus.result_pix), 0);
        reset = 1'b0;
        run_op(3'b110, 2'd0, fill(2), fill(3), fill(0), 0, cyc);
        chk("t6_cycle", cyc, 5);
        chk("t6_gx_after", longint'(bus.result_gx), 24);

        // Randomized traffic, checked cycle by cycle against the model
        for (int t = 0; t < 40; t++) begin
            logic [2:0] op;
            int pick, mode, extra;
            pick = int'($urandom_range(0, 9));
            if (pick == 0)     op = 3'($urandom_range(0, 5));
            else if (pick < 5) op = 3'b110;
            else               op = 3'b111;
            mode  = int'($urandom_range(0, 3));
            extra = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : 0;
            run_op(op, 2'($urandom_range(0, 3)), rand_mat(mode), rand_mat(mode), rand_mat(mode), extra, cyc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
